// File: rtl/apb_to_reg_v3.sv
// apb_to_reg_v3 : APB4 subordinate to regbus request/response bridge.
//
// Captures one APB transfer in IDLE, presents it on the regbus until the
// target answers (or a timeout fires), then completes the APB access phase.
// Optional privilege filtering rejects unprivileged accesses without ever
// touching the target.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   psel_i, penable_i  APB select / enable
//   pwrite_i, paddr_i  APB direction / address
//   pprot_i            APB protection, bit 0 = privileged
//   pstrb_i, pwdata_i  APB write strobes / write data
//   prdata_o           APB read data (zero unless pready_o)
//   pready_o           APB transfer complete
//   pslverr_o          APB transfer error (zero unless pready_o)
//   reg_req_o          regbus request (addr, write, wdata, wstrb, valid)
//   reg_rsp_i          regbus response (rdata, error, ready)
//   timeout_o          pulse in the last REQ cycle when the target never answered
//   busy_o             high whenever the bridge is not IDLE

package apb_to_reg_v3_pkg;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic          valid;
    } reg_req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
        logic          ready;
    } reg_rsp_t;
endpackage

module apb_to_reg_v3 #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 16,
    parameter bit          RequirePriv   = 1'b0,
    parameter type         reg_req_t     = apb_to_reg_v3_pkg::reg_req_t,
    parameter type         reg_rsp_t     = apb_to_reg_v3_pkg::reg_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [2:0]             pprot_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output reg_req_t               reg_req_o,
    input  reg_rsp_t               reg_rsp_i,
    output logic                   timeout_o,
    output logic                   busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    // A zero-width counter is illegal, so keep one bit when the timeout is off.
    localparam int unsigned CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned CntMaxI = (TimeoutCycles > 0) ? TimeoutCycles : 1;
    localparam int unsigned TmoI    = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [CntW-1:0] CntMax  = CntW'(CntMaxI);
    localparam logic [CntW-1:0] TmoLast = CntW'(TmoI);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [AddrWidth-1:0]   r_addr;
    logic                   r_write;
    logic [DataWidth-1:0]   r_wdata;
    logic [StrbWidth-1:0]   r_wstrb;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_err;
    logic [CntW-1:0]        r_cnt;

    logic w_reject;
    logic w_tmo_hit;
    logic w_pready;
    logic w_unused_prot;

    assign w_unused_prot = ^pprot_i[2:1];

    assign w_reject  = RequirePriv && !pprot_i[0];
    // ready in the same cycle beats the timeout.
    assign w_tmo_hit = (TimeoutCycles > 0) && (r_state == S_REQ) &&
                       !reg_rsp_i.ready && (r_cnt == TmoLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (psel_i) begin
                        r_addr  <= paddr_i;
                        r_write <= pwrite_i;
                        r_wdata <= pwdata_i;
                        r_wstrb <= pwrite_i ? pstrb_i : '0;
                        if (w_reject) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (reg_rsp_i.ready) begin
                        r_rdata <= r_write ? '0 : reg_rsp_i.rdata;
                        r_err   <= reg_rsp_i.error;
                        r_state <= S_RESP;
                    end else if (w_tmo_hit) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                S_RESP: begin
                    // Completes or, if psel already dropped, silently discards.
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // regbus side: payload always follows the capture registers.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = r_addr;
        reg_req_o.write = r_write;
        reg_req_o.wdata = r_wdata;
        reg_req_o.wstrb = r_wstrb;
        reg_req_o.valid = (r_state == S_REQ);
    end

    // APB side: decode of state with psel/penable only, never reg_rsp_i.
    assign w_pready  = (r_state == S_RESP) && psel_i && penable_i;
    assign pready_o  = w_pready;
    assign prdata_o  = w_pready ? r_rdata : '0;
    assign pslverr_o = w_pready & r_err;
    assign timeout_o = w_tmo_hit;
    assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_apb_to_reg_v3.sv
// Directed bench for apb_to_reg_v3: two instances, one plain (A) and one
// with privilege filtering (B), both with a 4-cycle response timeout.
module tb_apb_to_reg_v3;
    import apb_to_reg_v3_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic        tmo_a, tmo_b, busy_a, busy_b;
    reg_req_t    req_a, req_b;
    reg_rsp_t    rsp_a, rsp_b, rsp_drv;
    logic        sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_to_reg_v3 #(.TimeoutCycles(4), .RequirePriv(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .psel_i(psel_a), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pprot_i(pprot), .pstrb_i(pstrb),
        .pwdata_i(pwdata), .prdata_o(prdata_a), .pready_o(pready_a),
        .pslverr_o(pslverr_a), .reg_req_o(req_a), .reg_rsp_i(rsp_a),
        .timeout_o(tmo_a), .busy_o(busy_a));

    apb_to_reg_v3 #(.TimeoutCycles(4), .RequirePriv(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .psel_i(psel_b), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pprot_i(pprot), .pstrb_i(pstrb),
        .pwdata_i(pwdata), .prdata_o(prdata_b), .pready_o(pready_b),
        .pslverr_o(pslverr_b), .reg_req_o(req_b), .reg_rsp_i(rsp_b),
        .timeout_o(tmo_b), .busy_o(busy_b));

    assign rsp_a = sel ? '0 : rsp_drv;
    assign rsp_b = sel ? rsp_drv : '0;

    // view of the instance under test
    reg_req_t    creq;
    logic        ct, cp, cerr, cb;
    logic [31:0] cprd;
    assign creq = sel ? req_b : req_a;
    assign ct   = sel ? tmo_b : tmo_a;
    assign cp   = sel ? pready_b : pready_a;
    assign cerr = sel ? pslverr_b : pslverr_a;
    assign cb   = sel ? busy_b : busy_a;
    assign cprd = sel ? prdata_b : prdata_a;

    // observations of the last transfer
    int          vcnt, tcnt, tcyc, rcnt, rcyc, abad;
    logic [31:0] ob_rd, ob_wd;
    logic        ob_err;
    logic [3:0]  ob_strb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // waits < 0: target never answers
    task automatic xfer(input bit b, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [2:0] prot, input int waits, input bit terr,
                        input logic [31:0] trd, input bit abort);
        bit fire, done;
        sel = b; vcnt = 0; tcnt = 0; tcyc = 0; rcnt = 0; rcyc = 0; abad = 0;
        ob_rd = '0; ob_wd = '0; ob_err = 1'b0; ob_strb = '1;
        fire = 1'b0; done = 1'b0;
        @(posedge clk); #1;
        if (b) psel_b = 1'b1; else psel_a = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        pstrb = strb; pprot = prot;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            rsp_drv = '0;
            if (abort && fire) begin
                psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
            end
            fire = 1'b0;
            if (creq.valid) begin
                vcnt++;
                if (creq.addr !== addr) abad++;
                ob_strb = creq.wstrb;
                ob_wd   = creq.wdata;
                if (waits >= 0 && vcnt == waits + 1) begin
                    rsp_drv.ready = 1'b1;
                    rsp_drv.error = terr;
                    rsp_drv.rdata = trd;
                    fire = 1'b1;
                end
            end
            @(negedge clk);
            if (ct) begin tcnt++; tcyc = c; end
            if (cp) begin rcnt++; rcyc = c; ob_rd = cprd; ob_err = cerr; done = 1'b1; end
            if (abort && !cb) done = 1'b1;
        end
        @(posedge clk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; rsp_drv = '0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pprot = '0; pstrb = '0; rsp_drv = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_a", {31'b0, |req_a}, 32'd0);
        chk("rst_req_b", {31'b0, |req_b}, 32'd0);
        chk("rst_pready", {30'b0, pready_a, pready_b}, 32'd0);
        chk("rst_pslverr", {30'b0, pslverr_a, pslverr_b}, 32'd0);
        chk("rst_prdata", prdata_a | prdata_b, 32'd0);
        chk("rst_tmo_busy", {28'b0, tmo_a, tmo_b, busy_a, busy_b}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // write, zero waits; rdata from target must be ignored
        xfer(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 3'b001, 0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("wr_vcnt", vcnt, 1);
        chk("wr_strb", {28'b0, ob_strb}, 32'h3);
        chk("wr_wdata", ob_wd, 32'hDEADBEEF);
        chk("wr_rcyc", rcyc, 2);
        chk("wr_err", {31'b0, ob_err}, 0);
        chk("wr_rdata", ob_rd, 0);

        // read, 3 waits: ready lands on the would-be timeout cycle
        xfer(1'b0, 1'b0, 32'h44, 32'h0, 4'b1111, 3'b001, 3, 1'b0, 32'h12345678, 1'b0);
        chk("rd_vcnt", vcnt, 4);
        chk("rd_strb", {28'b0, ob_strb}, 0);
        chk("rd_addr_stable", abad, 0);
        chk("rd_rcyc", rcyc, 5);
        chk("rd_rdata", ob_rd, 32'h12345678);
        chk("rd_err", {31'b0, ob_err}, 0);
        chk("rd_no_tmo", tcnt, 0);

        // timeout: target silent
        xfer(1'b0, 1'b0, 32'h48, 32'h0, 4'b0, 3'b001, -1, 1'b0, 32'h0, 1'b0);
        chk("to_vcnt", vcnt, 4);
        chk("to_tcnt", tcnt, 1);
        chk("to_tcyc", tcyc, 4);
        chk("to_rcyc", rcyc, 5);
        chk("to_err", {31'b0, ob_err}, 1);
        chk("to_rdata", ob_rd, 0);

        // write with ready on the 4th REQ cycle
        xfer(1'b0, 1'b1, 32'h4C, 32'hCAFEF00D, 4'b1100, 3'b001, 3, 1'b0, 32'h0, 1'b0);
        chk("to4_tcnt", tcnt, 0);
        chk("to4_err", {31'b0, ob_err}, 0);
        chk("to4_rcyc", rcyc, 5);

        // privilege reject on B
        xfer(1'b1, 1'b0, 32'h50, 32'h0, 4'b0, 3'b000, 0, 1'b0, 32'h0, 1'b0);
        chk("pv_vcnt", vcnt, 0);
        chk("pv_rcyc", rcyc, 1);
        chk("pv_err", {31'b0, ob_err}, 1);
        chk("pv_rdata", ob_rd, 0);

        // privileged access on B goes through
        xfer(1'b1, 1'b0, 32'h54, 32'h0, 4'b0, 3'b001, 1, 1'b0, 32'hA5A5_5A5A, 1'b0);
        chk("pv1_vcnt", vcnt, 2);
        chk("pv1_rcyc", rcyc, 3);
        chk("pv1_rdata", ob_rd, 32'hA5A5_5A5A);
        chk("pv1_err", {31'b0, ob_err}, 0);

        // target error
        xfer(1'b0, 1'b0, 32'h58, 32'h0, 4'b0, 3'b001, 0, 1'b1, 32'h0BAD_0BAD, 1'b0);
        chk("te_err", {31'b0, ob_err}, 1);
        chk("te_rcyc", rcyc, 2);
        chk("te_rdata", ob_rd, 32'h0BAD_0BAD);

        // abort: psel drops in RESP
        xfer(1'b0, 1'b0, 32'h5C, 32'h0, 4'b0, 3'b001, 0, 1'b0, 32'h1111_2222, 1'b1);
        chk("ab_pready_cnt", rcnt, 0);
        chk("ab_idle", {31'b0, busy_a}, 0);

        // reset while valid is high
        sel = 1'b0;
        @(posedge clk); #1;
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h80; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("mr_valid_pre", {31'b0, req_a.valid}, 1);
        rst = 1'b1;
        #1;
        chk("mr_req", {31'b0, |req_a}, 0);
        chk("mr_pready_busy", {29'b0, pready_a, busy_a, tmo_a}, 0);
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 3'b001, 0, 1'b0, 32'h1357_9BDF, 1'b0);
        chk("pr_rcyc", rcyc, 2);
        chk("pr_rdata", ob_rd, 32'h1357_9BDF);
        chk("pr_err", {31'b0, ob_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
